// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants, FSM state type and one-hot helper for priority_encoder_4x2
package encoder_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [N_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/pri_pick4.sv
// rtl/pri_pick4.sv - combinational picker: first set bit searching upward from base, wrapping
module pri_pick4
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  req_set,
  input  logic [CODE_W-1:0] base,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   low;

  // Rotate so that 'base' lands on bit 0, isolate the lowest set bit, then undo the rotation.
  assign dbl = {req_set, req_set} >> base;
  assign rot = dbl[N_REQ-1:0];
  assign low = rot & (~rot + N_REQ'(1));
  assign idx = base + onehot_to_code(low);
  assign any = |req_set;

endmodule

// File: rtl/priority_encoder_4x2.sv
// rtl/priority_encoder_4x2.sv - registered 4-to-2 priority encoder with sticky capture and valid/ack
// Optional rotating priority when ROUND_ROBIN_EN is defined; fixed priority (bit 3 highest) otherwise.
module priority_encoder_4x2
  import encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              en,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending
);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [N_REQ-1:0]    pending_q, pending_d, clr;
  logic [N_REQ-1:0]    pick_set;
  logic [CODE_W-1:0]   pick_base, pick_idx, grant_code;
  logic                pick_any;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0]   last_q;

  assign pick_set   = pending_q;
  assign pick_base  = last_q + 2'd1;
  assign grant_code = pick_idx;
`else
  // Bit-reversed set searched from 0 gives bit 3 first; invert the index to map it back.
  assign pick_set   = {pending_q[0], pending_q[1], pending_q[2], pending_q[3]};
  assign pick_base  = '0;
  assign grant_code = ~pick_idx;
`endif

  pri_pick4 u_pick (
    .req_set (pick_set),
    .base    (pick_base),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    clr = '0;
    if (state_q == PRESENT && ack) clr[code_q] = 1'b1;
  end

  // Set wins over clear so a re-request on the acked bit stays pending.
  assign pending_d = (pending_q & ~clr) | (req & {N_REQ{en}});

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          code_d  = grant_code;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pending_q <= '0;
`ifdef ROUND_ROBIN_EN
      last_q    <= 2'd3;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
`ifdef ROUND_ROBIN_EN
      if (state_q == IDLE && pick_any) last_q <= grant_code;
`endif
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == PRESENT);
  assign pending = pending_q;

endmodule

// File: tb/tb_priority_encoder_4x2.sv
// tb/tb_priority_encoder_4x2.sv - directed self-checking bench for priority_encoder_4x2
module tb_priority_encoder_4x2;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic [3:0] pending;

  int tests_run;
  int tests_failed;

  priority_encoder_4x2 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .en      (en),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; en = 1'b1; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; en = 1'b1; ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if ({valid, code, pending} !== 7'b0) begin
        tests_failed++;
        $display("FAIL reset_during[%0d]: valid=%b code=%0d pending=%b, want 0/0/0000", i, valid, code, pending);
      end
    end
    rst = 1'b0; req = 4'b0000;
    tick();
    tests_run++;
    if ({valid, code, pending} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_after: valid=%b code=%0d pending=%b, want 0/0/0000", valid, code, pending);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tests_run++;
    if (pending !== 4'b0100 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_capture: pending=%b valid=%b, want 0100/0", pending, valid);
    end
    tick();
    tests_run++;
    if (valid !== 1'b1 || code !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_grant: valid=%b code=%0d, want 1/2", valid, code);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (valid !== 1'b1 || code !== 2'd2) begin
        tests_failed++;
        $display("FAIL single_hold[%0d]: valid=%b code=%0d, want 1/2", i, valid, code);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || pending !== 4'b0000 || code !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_ack: valid=%b pending=%b code=%0d, want 0/0000/2", valid, pending, code);
    end
  endtask

  task automatic test_multi();
    logic [1:0] exp_seq [3];
`ifdef ROUND_ROBIN_EN
    exp_seq = '{2'd0, 2'd1, 2'd3};
`else
    exp_seq = '{2'd3, 2'd1, 2'd0};
`endif
    do_reset();
    req = 4'b1011;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (valid !== 1'b1 || code !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL multi_grant[%0d]: valid=%b code=%0d, want 1/%0d", i, valid, code, exp_seq[i]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tests_run++;
      if (valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL multi_drop[%0d]: valid=%b, want 0", i, valid);
      end
    end
    tests_run++;
    if (pending !== 4'b0000) begin
      tests_failed++;
      $display("FAIL multi_drained: pending=%b, want 0000", pending);
    end
  endtask

  task automatic test_enable();
    logic [1:0] exp_code;
`ifdef ROUND_ROBIN_EN
    exp_code = 2'd0;
`else
    exp_code = 2'd3;
`endif
    do_reset();
    en = 1'b0; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (pending !== 4'b0000 || valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL enable_blocked[%0d]: pending=%b valid=%b, want 0000/0", i, pending, valid);
      end
    end
    en = 1'b1;
    tick();
    req = 4'b0000;
    tick();
    tests_run++;
    if (valid !== 1'b1 || code !== exp_code || pending !== 4'b1111) begin
      tests_failed++;
      $display("FAIL enable_grant: valid=%b code=%0d pending=%b, want 1/%0d/1111", valid, code, pending, exp_code);
    end
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tests_run++;
    if (valid !== 1'b1 || code !== 2'd2) begin
      tests_failed++;
      $display("FAIL collide_pre: valid=%b code=%0d, want 1/2", valid, code);
    end
    ack = 1'b1; req = 4'b0100;
    tick();
    ack = 1'b0; req = 4'b0000;
    tests_run++;
    if (valid !== 1'b0 || pending !== 4'b0100) begin
      tests_failed++;
      $display("FAIL collide_ack: valid=%b pending=%b, want 0/0100", valid, pending);
    end
    tick();
    tests_run++;
    if (valid !== 1'b1 || code !== 2'd2) begin
      tests_failed++;
      $display("FAIL collide_regrant: valid=%b code=%0d, want 1/2", valid, code);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_code;
`ifdef ROUND_ROBIN_EN
    exp_code = 2'd2;
`else
    exp_code = 2'd3;
`endif
    do_reset();
    req = 4'b1100;
    tick();
    req = 4'b0000;
    tick();
    tests_run++;
    if (valid !== 1'b1 || code !== exp_code || pending !== 4'b1100) begin
      tests_failed++;
      $display("FAIL midrst_pre: valid=%b code=%0d pending=%b, want 1/%0d/1100", valid, code, pending, exp_code);
    end
    rst = 1'b1; req = 4'b0011;
    tick();
    rst = 1'b0; req = 4'b0000;
    tests_run++;
    if ({valid, code, pending} !== 7'b0) begin
      tests_failed++;
      $display("FAIL midrst_post: valid=%b code=%0d pending=%b, want 0/0/0000", valid, code, pending);
    end
    // Stray ack during the IDLE cycle that already holds a pending bit must not clear it.
    req = 4'b0010;
    tick();
    req = 4'b0000; ack = 1'b1;
    tick();
    ack = 1'b0;
    tests_run++;
    if (pending !== 4'b0010 || valid !== 1'b1 || code !== 2'd1) begin
      tests_failed++;
      $display("FAIL stray_ack: pending=%b valid=%b code=%0d, want 0010/1/1", pending, valid, code);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; req = 4'b0000; en = 1'b1; ack = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_enable();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/priority_encoder_4x2.md
# priority_encoder_4x2

Registered 4-to-2 priority encoder with sticky request capture and a valid/ack handshake. It is the encode-side counterpart to the 2-to-4 enable decoder. Four request lines are latched into a pending set, one pending index is presented as a 2-bit code with `valid`, the code is held until the consumer acks, and then the serviced bit is retired. It sits between request sources (interrupt-style lines) and a consumer that drives a 2X4 decoder or indexes a 4-entry resource.

## Interface
- Parameters: none. Width is fixed at 4 requests to a 2-bit code. Constants live in the package.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `req`  input  4  request lines, level-sampled every cycle; bit i requests code i.
- `en`  input  1  capture enable; when low, new requests are not captured.
- `ack`  input  1  consumer accepts the presented code; meaningful only while `valid`=1.
- `code`  output  2  encoded index of the granted request.
- `valid`  output  1  `code` is a live grant.
- `pending`  output  4  current pending-request set.

## Operation
- Pending update every cycle: `pending <= (pending & ~clr) | (req & {4{en}})`.
  - `clr` is the one-hot of `code` when `ack & valid`, else 0.
  - Set wins over clear: a request on the bit being acked in the same cycle stays pending.
- FSM, two states, reset to IDLE.
  - IDLE: if `pending` != 0, select an index, register it into `code`, set `valid`=1, go to PRESENT. Otherwise stay in IDLE with `valid`=0.
  - PRESENT: `code` and `valid` are held stable. On `ack`: clear `pending[code]`, set `valid`=0, go to IDLE. Without `ack`, stay in PRESENT indefinitely.
- Selection uses only the registered `pending`, never raw `req`.
- Selection when nothing is pending: no grant is made and `code` is unchanged.
- `ack` while in IDLE (`valid`=0) is ignored; no pending bit changes.
- `en`=0 blocks capture only. Already-pending bits are still serviced.
- `code` retains the last granted value after `valid` falls.
- Reset values: `code`=2'b00, `valid`=0, `pending`=4'b0000, state IDLE. Round-robin pointer (when compiled in) resets to 3.

## Timing
- Capture: `req` high in cycle N with `en`=1 sets `pending` at edge N→N+1.
- Grant: `valid`/`code` appear at edge N+1→N+2, i.e. two cycles after `req`, when previously idle.
- Ack: `ack` in cycle M drops `valid` and clears the pending bit at edge M→M+1.
- Next grant appears at edge M+1→M+2 at the earliest. Minimum spacing between successive grants is 2 cycles.
- `rst` mid-operation: at the next edge all state returns to reset values. Pending requests are discarded; `req` sampled during `rst` is not captured.

## Configuration
- `ROUND_ROBIN_EN` not defined: fixed priority, bit 3 highest, bit 0 lowest.
- `ROUND_ROBIN_EN` defined: rotating priority.
  - A 2-bit `last` register is updated to `code` on each grant.
  - Search order starts at `last+1` mod 4 and wraps. With `last` reset to 3, the first search starts at bit 0.
  - Ports and timing are unchanged.

## Structure
- Package `encoder_pkg`:
  - `N_REQ`=4 and `CODE_W`=2.
  - `state_t` enum {IDLE, PRESENT}.
  - One-hot-to-code helper function.
- Sub-module `pri_pick4`: combinational picker.
  - Inputs: 4-bit set and 2-bit start base.
  - Outputs: 2-bit index and `any`.
  - Fixed mode ties the base so that bit 3 is searched first.
  - Top level holds pending, FSM, code/valid and the `last` registers.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=4'b1111, `en`=1 → `valid`=0, `code`=0, `pending`=0 during and one cycle after reset.
- Single request: `req`=4'b0100 for one cycle at N → `valid`=1, `code`=2 from N+2. Hold `ack`=0 for 5 cycles → `code` stays 2. Pulse `ack` → next cycle `valid`=0, `pending`=0.
- Multiple requests: pulse `req`=4'b1011, ack each grant one cycle after it appears.
  - Fixed priority: code sequence 3,1,0.
  - `ROUND_ROBIN_EN`: code sequence 0,1,3.
  - Then `pending`=0.
- Enable gating: `en`=0 with `req`=4'b1111 for 4 cycles → `pending`=0, `valid` stays 0. Set `en`=1 → grant 2 cycles later.
- Set/clear collision: while `code`=2 is presented, drive `ack`=1 and `req`=4'b0100 in the same cycle → `pending[2]` stays 1, `valid` falls, and `code`=2 is re-presented 2 cycles after the ack.
- Reset mid-grant: `valid`=1 with `pending`=4'b1100, assert `rst` one cycle → next cycle `valid`=0, `code`=0, `pending`=0. Stray `ack` in IDLE causes no change.
